mod_n_counter_ext: RTL and testbench
====================================

# mod_n_counter_ext

Parametrised modulo-N counter with count direction control, enable, synchronous clear, synchronous load with range checking, and an optional saturating mode. It generalises the single-direction N_counter. It also provides cascade and event outputs (terminal count, wrap pulse, load error), so several instances can be chained into multi-digit or prescaled timebases.

## Interface
- N, 20: modulus; count range 0..N-1. Legal range 2 <= N <= 2**WIDTH. Any other value is an elaboration error ($error in a generate check).
- WIDTH, 5: counter width in bits.
- SATURATE, 0: 0 = wrap mode, 1 = saturate (hold at the end of range) mode.

Ports. Single clock. Reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  count enable.
- up  in  1  direction; 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- out  out  WIDTH  current count (registered).
- tc  out  1  terminal count (combinational from out and up).
- wrap  out  1  registered one-cycle pulse; count wrapped.
- load_err  out  1  registered one-cycle pulse; load rejected.

## Operation
- Reset (asynchronous, immediate, independent of clk):
  - out = 0, wrap = 0, load_err = 0.
  - tc follows: it is 1 if up = 0, else 0.
- Per-edge priority, highest first: clr > load > en > hold.
- clr = 1:
  - out <= 0, wrap <= 0, load_err <= 0.
  - load and en are ignored that cycle.
- load = 1 (clr = 0):
  - load_val < N: out <= load_val, load_err <= 0.
  - load_val >= N: out unchanged, load_err <= 1.
  - wrap <= 0. en is ignored that cycle.
- en = 1, up = 1:
  - out < N-1: out <= out + 1.
  - out == N-1, SATURATE = 0: out <= 0, wrap <= 1.
  - out == N-1, SATURATE = 1: out holds N-1, wrap <= 0.
- en = 1, up = 0:
  - out > 0: out <= out - 1.
  - out == 0, SATURATE = 0: out <= N-1, wrap <= 1.
  - out == 0, SATURATE = 1: out holds 0, wrap <= 0.
- en = 0: out holds. wrap and load_err are 0 on every edge where they are not set.
- tc = (up && out == N-1) || (!up && out == 0). It does not depend on en.
  - Cascading: drive the next stage's en with en & tc of this stage, and use the same up.
- Arithmetic:
  - Compare and increment at WIDTH+1 bits internally, so N = 2**WIDTH is legal.
  - In that case N-1 is all ones and wrap is the natural overflow.
  - out never holds a value >= N.
- Direction change mid-count: no state change. The next enabled edge simply steps the other way; tc re-evaluates combinationally.

## Timing
- out, wrap, load_err: registered, one-cycle latency from the qualifying edge.
  - wrap and load_err are high for exactly the cycle in which the new out value is visible.
- tc: zero latency from out/up (combinational). Consumers sample it at the next edge.
- Back-to-back wraps (N = 2, en held high, wrap mode): wrap is high every other cycle.
- Reset asserted mid-count: out goes to 0 without waiting for clk.
  - Reset deasserted: the first edge with en = 1 gives out = 1 (up) or N-1 (down).
- load and en high together: only the load takes effect; no count step that cycle.
- clr and an out-of-range load together: clr wins and load_err = 0.

## Test plan (N = 20, WIDTH = 5 unless stated)
- Reset then up-count: reset high 20 ns then low, en = 1, up = 1 for 21 edges.
  - Required: out 0,1,..,19,0.
  - wrap high only in the cycle out = 0 after 19.
  - tc high only while out = 19.
- Down-count with wrap: load 2, then en = 1, up = 0.
  - Required: out 2,1,0,19,18.
  - wrap high in the cycle out = 19; tc high while out = 0.
- Load range check: load_val = 7 gives out = 7, load_err = 0. load_val = 25 leaves out = 7 with load_err = 1 for one cycle.
  - With load = 1 and en = 1 and load_val = 3: out = 3, no increment.
- Saturate mode (SATURATE = 1): up-count from 17 with en held.
  - Required: out 18,19,19,19; wrap never asserts.
  - Then up = 0 from 1: out 0,0.
- Priority and async reset:
  - clr = 1 with load = 1, load_val = 25: out = 0, load_err = 0.
  - Assert reset mid-cycle at out = 12: out = 0 before the next rising edge.
- Full-range and cascade (N = 32, WIDTH = 5): two instances, the second enabled by en & tc of the first.
  - Required: first wraps 31→0 with wrap = 1.
  - The second increments exactly once per first-stage wrap: 0→1 after 32 edges, 1→2 after 64.

Source files
------------

// File: rtl/mod_n_counter_ext.sv
// mod_n_counter_ext: modulo-N up/down counter with enable, synchronous
// clear, range-checked synchronous load and an optional saturating mode.
// Provides terminal count (tc), a registered wrap pulse and a registered
// load error pulse so instances can be cascaded into larger timebases.
module mod_n_counter_ext #(
    parameter int N        = 20,
    parameter int WIDTH    = 5,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (N < 2 || N > (2 ** WIDTH)) begin : g_bad_modulus
            $error("mod_n_counter_ext: N must satisfy 2 <= N <= 2**WIDTH");
        end
    endgenerate

    // Range limits held one bit wider than the count so N = 2**WIDTH fits.
    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(N - 1);
    localparam logic [WIDTH:0] NMOD = (WIDTH + 1)'(N);

    logic at_last;
    logic at_zero;
    logic load_ok;

    // End-of-range detection and load range check at WIDTH+1 bits.
    always_comb begin
        at_last = ({1'b0, out} == LAST);
        at_zero = (out == '0);
        load_ok = ({1'b0, load_val} < NMOD);
    end

    // Terminal count depends only on the current count and direction.
    assign tc = up ? at_last : at_zero;

    // Count register with clr > load > en > hold priority; pulses default low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out      <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                out <= '0;
            end else if (load) begin
                if (load_ok) begin
                    out <= load_val;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (up) begin
                    if (!at_last) begin
                        out <= out + WIDTH'(1);
                    end else if (!SATURATE) begin
                        out  <= '0;
                        wrap <= 1'b1;
                    end
                end else begin
                    if (!at_zero) begin
                        out <= out - WIDTH'(1);
                    end else if (!SATURATE) begin
                        out  <= LAST[WIDTH-1:0];
                        wrap <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_n_counter_ext.sv
// Self-checking bench for mod_n_counter_ext: wrap-mode N=20, saturate-mode
// N=20, back-to-back N=2 and a two-stage N=32 cascade, all compared against
// an arithmetic reference model of the counter behaviour.
module tb_mod_n_counter_ext;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Main instance: N=20 wrap mode
    logic en = 0, up = 0, clr = 0, load = 0;
    logic [4:0] load_val = '0;
    logic [4:0] out;
    logic tc, wrap, load_err;

    // Saturating instance: N=20
    logic s_en = 0, s_up = 0, s_clr = 0, s_load = 0;
    logic [4:0] s_load_val = '0;
    logic [4:0] s_out;
    logic s_tc, s_wrap, s_load_err;

    // Back-to-back instance: N=2, WIDTH=1
    logic b_en = 0;
    logic [0:0] b_out;
    logic [0:0] b_lv = '0;
    logic b_tc, b_wrap, b_load_err;

    // Cascade: two N=32 stages
    logic c_en = 0, c_up = 1;
    logic [4:0] c_lv = '0;
    logic [4:0] c0_out, c1_out;
    logic c0_tc, c0_wrap, c0_lerr, c1_tc, c1_wrap, c1_lerr, c1_en;
    logic zero = 1'b0;
    assign c1_en = c_en & c0_tc;

    mod_n_counter_ext #(.N(20), .WIDTH(5), .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .out(out), .tc(tc), .wrap(wrap), .load_err(load_err));

    mod_n_counter_ext #(.N(20), .WIDTH(5), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(s_en), .up(s_up), .clr(s_clr), .load(s_load),
        .load_val(s_load_val), .out(s_out), .tc(s_tc), .wrap(s_wrap), .load_err(s_load_err));

    mod_n_counter_ext #(.N(2), .WIDTH(1), .SATURATE(1'b0)) dut_b2b (
        .clk(clk), .reset(reset), .en(b_en), .up(1'b1), .clr(zero), .load(zero),
        .load_val(b_lv), .out(b_out), .tc(b_tc), .wrap(b_wrap), .load_err(b_load_err));

    mod_n_counter_ext #(.N(32), .WIDTH(5), .SATURATE(1'b0)) dut_c0 (
        .clk(clk), .reset(reset), .en(c_en), .up(c_up), .clr(zero), .load(zero),
        .load_val(c_lv), .out(c0_out), .tc(c0_tc), .wrap(c0_wrap), .load_err(c0_lerr));

    mod_n_counter_ext #(.N(32), .WIDTH(5), .SATURATE(1'b0)) dut_c1 (
        .clk(clk), .reset(reset), .en(c1_en), .up(c_up), .clr(zero), .load(zero),
        .load_val(c_lv), .out(c1_out), .tc(c1_tc), .wrap(c1_wrap), .load_err(c1_lerr));

    // Reference model state
    int  m_cnt = 0;  bit m_wrap = 0;  bit m_lerr = 0;
    int  s_cnt = 0;  bit s_mwrap = 0; bit s_mlerr = 0;

    // Counter behaviour expressed as modular / clamped arithmetic.
    function automatic void ref_step(input int n, input bit sat, input bit c, input bit l,
                                     input bit e, input bit u, input int lv,
                                     inout int cnt, output bit w, output bit le);
        w = 0; le = 0;
        if (c) cnt = 0;
        else if (l) begin
            if (lv < n) cnt = lv;
            else le = 1;
        end else if (e) begin
            if (sat) cnt = u ? ((cnt + 1 > n - 1) ? n - 1 : cnt + 1)
                             : ((cnt - 1 < 0) ? 0 : cnt - 1);
            else begin
                w   = u ? (cnt + 1 == n) : (cnt == 0);
                cnt = (cnt + (u ? 1 : n - 1)) % n;
            end
        end
    endfunction

    function automatic bit tc_of(input int n, input bit u, input int cnt);
        return (u && cnt == n - 1) || (!u && cnt == 0);
    endfunction

    // Apply inputs to the main instance, advance the model, then one edge.
    task automatic drive_main(input bit c, input bit l, input bit e, input bit u, input int v);
        clr = c; load = l; en = e; up = u; load_val = 5'(v);
        ref_step(20, 0, c, l, e, u, v, m_cnt, m_wrap, m_lerr);
        @(posedge clk); #1;
    endtask

    task automatic drive_sat(input bit c, input bit l, input bit e, input bit u, input int v);
        s_clr = c; s_load = l; s_en = e; s_up = u; s_load_val = 5'(v);
        ref_step(20, 1, c, l, e, u, v, s_cnt, s_mwrap, s_mlerr);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        up = 1; #1;
        tests++; if (out !== 5'd0) begin fails++; $display("FAIL reset_out got=%0d exp=0", out); end
        tests++; if (wrap !== 1'b0 || load_err !== 1'b0) begin fails++; $display("FAIL reset_pulses got=%b%b exp=00", wrap, load_err); end
        tests++; if (tc !== 1'b0) begin fails++; $display("FAIL reset_tc_up got=%b exp=0", tc); end
        up = 0; #1;
        tests++; if (tc !== 1'b1) begin fails++; $display("FAIL reset_tc_down got=%b exp=1", tc); end
        up = 1; #18;
        reset = 0;
    endtask

    task automatic test_up_count;
        for (int k = 0; k < 21; k++) begin
            drive_main(0, 0, 1, 1, 0);
            tests++; if (out !== 5'(m_cnt)) begin fails++; $display("FAIL up_out[%0d] got=%0d exp=%0d", k, out, m_cnt); end
            tests++; if (wrap !== m_wrap) begin fails++; $display("FAIL up_wrap[%0d] got=%b exp=%b", k, wrap, m_wrap); end
            tests++; if (tc !== tc_of(20, up, m_cnt)) begin fails++; $display("FAIL up_tc[%0d] got=%b exp=%b", k, tc, tc_of(20, up, m_cnt)); end
        end
    endtask

    task automatic test_down_wrap;
        drive_main(0, 1, 0, 0, 2);
        tests++; if (out !== 5'd2) begin fails++; $display("FAIL down_load got=%0d exp=2", out); end
        for (int k = 0; k < 4; k++) begin
            drive_main(0, 0, 1, 0, 0);
            tests++; if (out !== 5'(m_cnt)) begin fails++; $display("FAIL down_out[%0d] got=%0d exp=%0d", k, out, m_cnt); end
            tests++; if (wrap !== m_wrap) begin fails++; $display("FAIL down_wrap[%0d] got=%b exp=%b", k, wrap, m_wrap); end
            tests++; if (tc !== tc_of(20, 0, m_cnt)) begin fails++; $display("FAIL down_tc[%0d] got=%b exp=%b", k, tc, tc_of(20, 0, m_cnt)); end
        end
    endtask

    task automatic test_load_range;
        drive_main(0, 1, 0, 1, 7);
        tests++; if (out !== 5'd7 || load_err !== 1'b0) begin fails++; $display("FAIL load7 got=%0d/%b exp=7/0", out, load_err); end
        drive_main(0, 1, 0, 1, 25);
        tests++; if (out !== 5'd7 || load_err !== 1'b1) begin fails++; $display("FAIL load25 got=%0d/%b exp=7/1", out, load_err); end
        drive_main(0, 0, 0, 1, 0);
        tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL load_err_pulse got=%b exp=0", load_err); end
        drive_main(0, 1, 1, 1, 3);
        tests++; if (out !== 5'd3) begin fails++; $display("FAIL load_over_en got=%0d exp=3", out); end
    endtask

    task automatic test_priority;
        drive_main(1, 1, 1, 1, 25);
        tests++; if (out !== 5'd0 || load_err !== 1'b0) begin fails++; $display("FAIL clr_over_load got=%0d/%b exp=0/0", out, load_err); end
    endtask

    task automatic test_async_reset;
        drive_main(0, 1, 0, 1, 12);
        tests++; if (out !== 5'd12) begin fails++; $display("FAIL pre_reset got=%0d exp=12", out); end
        en = 1; #2;
        reset = 1; #1;
        tests++; if (out !== 5'd0) begin fails++; $display("FAIL async_reset got=%0d exp=0", out); end
        #1 reset = 0;
        m_cnt = 0;
        drive_main(0, 0, 1, 0, 0);
        tests++; if (out !== 5'd19 || wrap !== 1'b1) begin fails++; $display("FAIL post_reset_down got=%0d/%b exp=19/1", out, wrap); end
    endtask

    task automatic test_random;
        for (int k = 0; k < 300; k++) begin
            drive_main($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 31)));
            tests++;
            if (out !== 5'(m_cnt) || wrap !== m_wrap || load_err !== m_lerr || tc !== tc_of(20, up, m_cnt)) begin
                fails++;
                $display("FAIL rand[%0d] got out=%0d w=%b le=%b tc=%b exp out=%0d w=%b le=%b tc=%b",
                         k, out, wrap, load_err, tc, m_cnt, m_wrap, m_lerr, tc_of(20, up, m_cnt));
            end
        end
    endtask

    task automatic test_saturate;
        drive_sat(0, 1, 0, 1, 17);
        for (int k = 0; k < 4; k++) begin
            drive_sat(0, 0, 1, 1, 0);
            tests++; if (s_out !== 5'(s_cnt) || s_wrap !== 1'b0) begin fails++; $display("FAIL sat_up[%0d] got=%0d/%b exp=%0d/0", k, s_out, s_wrap, s_cnt); end
        end
        drive_sat(0, 1, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            drive_sat(0, 0, 1, 0, 0);
            tests++; if (s_out !== 5'd0 || s_wrap !== 1'b0) begin fails++; $display("FAIL sat_down[%0d] got=%0d/%b exp=0/0", k, s_out, s_wrap); end
        end
        for (int k = 0; k < 200; k++) begin
            drive_sat($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 31)));
            tests++;
            if (s_out !== 5'(s_cnt) || s_wrap !== s_mwrap || s_load_err !== s_mlerr || s_tc !== tc_of(20, s_up, s_cnt)) begin
                fails++;
                $display("FAIL sat_rand[%0d] got out=%0d w=%b le=%b exp out=%0d w=%b le=%b",
                         k, s_out, s_wrap, s_load_err, s_cnt, s_mwrap, s_mlerr);
            end
        end
    endtask

    task automatic test_back_to_back;
        b_en = 1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            tests++; if (b_out !== 1'(k % 2) || b_wrap !== (k % 2 == 0)) begin fails++; $display("FAIL b2b[%0d] got=%0d/%b exp=%0d/%b", k, b_out, b_wrap, k % 2, k % 2 == 0); end
        end
        b_en = 0;
    endtask

    task automatic test_cascade;
        c_up = 1; c_en = 1;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            tests++;
            if (c0_out !== 5'(k % 32) || c0_wrap !== (k % 32 == 0) || c1_out !== 5'(k / 32)) begin
                fails++;
                $display("FAIL cascade[%0d] got c0=%0d w=%b c1=%0d exp c0=%0d w=%b c1=%0d",
                         k, c0_out, c0_wrap, c1_out, k % 32, k % 32 == 0, k / 32);
            end
        end
        c_en = 0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load_range();
        test_priority();
        test_async_reset();
        test_random();
        test_saturate();
        test_back_to_back();
        test_cascade();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
